// File: rtl/vga_term_writer_pkg.sv
// Shared constants and state encoding for the terminal writer and the display stage.
package vga_term_writer_pkg;

  localparam int unsigned COLS       = 40;
  localparam int unsigned ROWS       = 24;
  localparam int unsigned VRAM_DEPTH = COLS * ROWS;

  localparam logic [7:0] CHR_CR  = 8'h8D;
  localparam logic [7:0] CHR_DDR = 8'h7F;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_WRITE  = 2'd1;
  localparam state_t ST_SCROLL = 2'd2;
  localparam state_t ST_CLEAR  = 2'd3;

endpackage

// File: rtl/vga_term_writer.sv
// Character-stream terminal writer: places CPU bytes into a circular VRAM,
// handling CR, column wrap, hardware scroll and full-screen clear.
module vga_term_writer
  import vga_term_writer_pkg::*;
#(
  parameter int unsigned COLS = vga_term_writer_pkg::COLS,
  parameter int unsigned ROWS = vga_term_writer_pkg::ROWS
) (
  input  logic       clk25,
  input  logic       rst,
  input  logic       enable,
  input  logic       address,
  input  logic       w_en,
  input  logic [7:0] din,
  input  logic       clr_screen_btn,
  output logic [9:0] vram_w_addr,
  output logic [5:0] vram_din,
  output logic       vram_w_en,
  output logic [4:0] top_row,
  output logic [5:0] h_cursor,
  output logic [4:0] v_cursor,
  output logic       busy
);

  localparam logic [5:0] LAST_COL = 6'(COLS - 1);
  localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);
  localparam logic [9:0] COLS_W   = 10'(COLS);
  localparam logic [9:0] ROWS_W   = 10'(ROWS);
  localparam logic [9:0] DEPTH_W  = 10'(COLS * ROWS);

  state_t     state;
  logic       char_seen;
  logic [9:0] cnt;
  logic [9:0] phys_sum;
  logic [9:0] phys_row;
  logic [9:0] cur_addr;
  logic [9:0] bottom_base;
  logic       accept;
  logic       do_newline;

  // top_row is the oldest row; after a scroll it becomes the new bottom row
  always_comb begin
    phys_sum    = {5'd0, top_row} + {5'd0, v_cursor};
    phys_row    = (phys_sum >= ROWS_W) ? phys_sum - ROWS_W : phys_sum;
    cur_addr    = phys_row * COLS_W + {4'd0, h_cursor};
    bottom_base = {5'd0, top_row} * COLS_W;
  end

  always_comb begin
    accept     = (state == ST_IDLE) & enable & w_en & ~address & ~char_seen & ~clr_screen_btn;
    do_newline = (accept & (din == CHR_CR)) | ((state == ST_WRITE) & (h_cursor == LAST_COL));
    busy       = (state != ST_IDLE);
  end

  always_ff @(posedge clk25) begin
    if (rst) begin
      state       <= ST_CLEAR;
      char_seen   <= 1'b0;
      cnt         <= 10'd0;
      vram_w_en   <= 1'b0;
      vram_w_addr <= 10'd0;
      vram_din    <= 6'd0;
      top_row     <= 5'd0;
      h_cursor    <= 6'd0;
      v_cursor    <= 5'd0;
    end else begin
      if (accept) begin
        char_seen <= 1'b1;
      end else if (!enable && !w_en) begin
        char_seen <= 1'b0;
      end
      vram_w_en <= 1'b0;

      if (clr_screen_btn && state != ST_CLEAR) begin
        state <= ST_CLEAR;
        cnt   <= 10'd0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (accept && din != CHR_CR && din != CHR_DDR) begin
              state       <= ST_WRITE;
              vram_w_en   <= 1'b1;
              vram_w_addr <= cur_addr;
              vram_din    <= {~din[6], din[4:0]};
            end
          end
          ST_WRITE: begin
            if (h_cursor != LAST_COL) begin
              h_cursor <= h_cursor + 6'd1;
              state    <= ST_IDLE;
            end
          end
          ST_SCROLL: begin
            // cnt is the offset of the next cell; cell 0 was issued on entry
            if (cnt == COLS_W) begin
              state <= ST_IDLE;
            end else begin
              vram_w_en   <= 1'b1;
              vram_w_addr <= vram_w_addr + 10'd1;
              vram_din    <= 6'd0;
              cnt         <= cnt + 10'd1;
            end
          end
          default: begin
            if (cnt == DEPTH_W) begin
              h_cursor <= 6'd0;
              v_cursor <= 5'd0;
              top_row  <= 5'd0;
              if (clr_screen_btn) cnt <= 10'd0;
              else                state <= ST_IDLE;
            end else begin
              vram_w_en   <= 1'b1;
              vram_w_addr <= cnt;
              vram_din    <= 6'd0;
              cnt         <= cnt + 10'd1;
            end
          end
        endcase

        if (do_newline) begin
          h_cursor <= 6'd0;
          if (v_cursor != LAST_ROW) begin
            v_cursor <= v_cursor + 5'd1;
            state    <= ST_IDLE;
          end else begin
            top_row     <= (top_row == LAST_ROW) ? 5'd0 : top_row + 5'd1;
            state       <= ST_SCROLL;
            cnt         <= 10'd1;
            vram_w_en   <= 1'b1;
            vram_w_addr <= bottom_base;
            vram_din    <= 6'd0;
          end
        end
      end
    end
  end

endmodule

// File: doc/vga_term_writer.md
VGA_TERM_WRITER -- requirements
Module: vga_term_writer

Interface
REQ-001 SHALL have parameter COLS, default 40, characters per row.
REQ-002 SHALL have parameter ROWS, default 24, rows per screen.
REQ-003 SHALL have port clk25  input  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port enable  input  1  bus clock-enable strobe.
REQ-006 SHALL have port address  input  1  register select; 0 = TX register.
REQ-007 SHALL have port w_en  input  1  active-high bus write strobe.
REQ-008 SHALL have port din  input  8  character byte from CPU.
REQ-009 SHALL have port clr_screen_btn  input  1  active-high clear request, level-sensitive.
REQ-010 SHALL have port vram_w_addr  output  10  VRAM write address.
REQ-011 SHALL have port vram_din  output  6  VRAM write data (glyph index).
REQ-012 SHALL have port vram_w_en  output  1  VRAM write strobe, one cycle per write.
REQ-013 SHALL have port top_row  output  5  physical VRAM row shown as screen row 0, for the display stage.
REQ-014 SHALL have port h_cursor  output  6  cursor column, for the display stage.
REQ-015 SHALL have port v_cursor  output  5  cursor logical row, for the display stage.
REQ-016 SHALL have port busy  output  1  high when not in IDLE; the CPU side uses it as "not ready".

Function
REQ-017 SHALL implement states IDLE, WRITE, SCROLL, CLEAR.
REQ-018 SHALL accept a character only in IDLE when enable & w_en & ~address & ~char_seen; acceptance sets char_seen.
REQ-019 SHALL clear char_seen when ~enable & ~w_en; offers while busy are not accepted, and char_seen stays clear so the offer is taken once IDLE is reached if the strobe persists.
REQ-020 SHALL compute the physical row as (top_row + v_cursor) mod ROWS and the address as physical_row*COLS + h_cursor, with all arithmetic 10 bits wide.
REQ-021 Printable char SHALL take IDLE->WRITE; vram_w_en SHALL pulse in the cycle after acceptance with vram_din = {~din[6], din[4:0]}; column SHALL then advance.
REQ-022 din = 8'h8D (CR) SHALL perform no VRAM write; it SHALL set h_cursor = 0 and execute a newline.
REQ-023 din = 8'h7F (PIA DDR setup) SHALL be ignored: no write and no cursor change.
REQ-024 Column advance from COLS-1 SHALL wrap to 0 and execute a newline.
REQ-025 Newline with v_cursor < ROWS-1 SHALL increment v_cursor and return to IDLE.
REQ-026 Newline with v_cursor = ROWS-1 SHALL keep v_cursor, set top_row = (top_row+1) mod ROWS, and enter SCROLL.
REQ-027 SCROLL SHALL write 0 to the COLS cells of the new bottom physical row, one per cycle, then return to IDLE (COLS cycles).
REQ-028 CLEAR SHALL write 0 to addresses 0..COLS*ROWS-1, one per cycle (960 cycles), then set h_cursor = 0, v_cursor = 0, top_row = 0 and return to IDLE.
REQ-029 clr_screen_btn high in any state other than CLEAR SHALL enter CLEAR at address 0 next cycle, aborting any WRITE or SCROLL; if still high when CLEAR ends, it SHALL re-enter CLEAR.
REQ-030 A character offer coinciding with clr_screen_btn SHALL be dropped.
REQ-031 vram_w_en SHALL be 0 in IDLE, and vram_w_addr SHALL never exceed COLS*ROWS-1.

Reset
REQ-032 rst SHALL force state CLEAR at address 0 with char_seen = 0, vram_w_en = 0, vram_w_addr = 0, vram_din = 0, top_row = 0, h_cursor = 0, v_cursor = 0, busy = 1.
REQ-033 rst asserted mid-SCROLL or mid-CLEAR SHALL restart a full CLEAR from address 0.

Structure
REQ-034 A shared package SHALL hold COLS, ROWS, VRAM_DEPTH (960), CHR_CR (8'h8D), CHR_DDR (8'h7F) and the state enum; the display stage SHALL import the same package.
REQ-035 The block SHALL have no sub-module; address arithmetic SHALL be inline.

Verification
REQ-036 Release rst, hold inputs low -> 960 writes of 0 to addresses 0..959, then busy = 0 and cursor (0,0).
REQ-037 After init, write din = 8'hC1 -> one vram_w_en pulse, addr 0, data 6'h01, h_cursor = 1; a second write is not accepted until enable and w_en both drop.
REQ-038 Send 40 chars 8'hC1 -> last write at addr 39, then h_cursor = 0 and v_cursor = 1; then send 8'h8D -> no write, v_cursor = 2, h_cursor = 0.
REQ-039 At v_cursor = 23 with top_row = 0, send 8'h8D -> top_row = 1, 40 zero writes to addrs 0..39, busy high for 40 cycles; the next char lands at addr 0 + h_cursor.
REQ-040 Assert clr_screen_btn mid-SCROLL -> CLEAR restarts at addr 0; afterwards top_row = 0 and cursor = (0,0); 8'h7F offered -> no write and no cursor change.
